// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: sequences a shared ALU/memory/IR/register-file
// datapath through IF/ID/EX/MEM/WB, with a memory-ready watchdog and a retired-instruction counter.
module multicycle_control #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 8,
  parameter int COUNT_W  = 32
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic [5:0]         opCode,
  input  logic               zero,
  input  logic               memReady,
  output logic               pcWrite,
  output logic               pcSrc,
  output logic               irWrite,
  output logic               iorD,
  output logic               memRead,
  output logic               memWrite,
  output logic               memToReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         aluOp,
  output logic               illegalOp,
  output logic               memTimeout,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instrCount
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADDR  = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXEC     = 4'd6,
    RWB      = 4'd7,
    BRANCH   = 4'd8,
    TRAP     = 4'd9
  } stateT;

  localparam logic [5:0]        OP_RTYPE  = 6'd0;
  localparam logic [5:0]        OP_BEQ    = 6'd4;
  localparam logic [5:0]        OP_LW     = 6'd35;
  localparam logic [5:0]        OP_SW     = 6'd43;
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  stateT             stateR;
  stateT             nextStateS;
  logic [WAIT_W-1:0] waitCntR;
  logic              retireS;
  logic              waitIncS;
  logic              setIllegalS;
  logic              setTimeoutS;
  logic              rawPcWrite;
  logic              rawIrWrite;
  logic              rawMemRead;
  logic              rawMemWrite;
  logic              rawRegWrite;

  // State, watchdog counter, retired count and sticky trap flags
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateR     <= FETCH;
      waitCntR   <= {WAIT_W{1'b0}};
      instrCount <= {COUNT_W{1'b0}};
      illegalOp  <= 1'b0;
      memTimeout <= 1'b0;
    end else begin
      stateR <= nextStateS;
      if (nextStateS != stateR) begin
        waitCntR <= {WAIT_W{1'b0}};
      end else if (waitIncS) begin
        waitCntR <= waitCntR + WAIT_W'(1);
      end else begin
        waitCntR <= waitCntR;
      end
      if (retireS) begin
        instrCount <= instrCount + COUNT_W'(1);
      end else begin
        instrCount <= instrCount;
      end
      illegalOp  <= illegalOp | setIllegalS;
      memTimeout <= memTimeout | setTimeoutS;
    end
  end

  // Next-state, retirement and trap decisions
  always_comb begin
    nextStateS  = stateR;
    retireS     = 1'b0;
    waitIncS    = 1'b0;
    setIllegalS = 1'b0;
    setTimeoutS = 1'b0;
    case (stateR)
      FETCH, MEMREAD, MEMWRITE: begin
        // A ready on the final allowed wait cycle still completes normally.
        if (memReady) begin
          case (stateR)
            FETCH:   nextStateS = DECODE;
            MEMREAD: nextStateS = MEMWB;
            default: begin
              nextStateS = FETCH;
              retireS    = 1'b1;
            end
          endcase
        end else if (waitCntR == LAST_WAIT) begin
          nextStateS  = TRAP;
          setTimeoutS = 1'b1;
        end else begin
          waitIncS = 1'b1;
        end
      end
      DECODE: begin
        case (opCode)
          OP_RTYPE:     nextStateS = EXEC;
          OP_LW, OP_SW: nextStateS = MEMADDR;
          OP_BEQ:       nextStateS = BRANCH;
          default: begin
            nextStateS  = TRAP;
            setIllegalS = 1'b1;
          end
        endcase
      end
      MEMADDR: begin
        if (opCode == OP_LW) begin
          nextStateS = MEMREAD;
        end else begin
          nextStateS = MEMWRITE;
        end
      end
      EXEC: nextStateS = RWB;
      MEMWB, RWB, BRANCH: begin
        nextStateS = FETCH;
        retireS    = 1'b1;
      end
      TRAP:    nextStateS = TRAP;
      default: nextStateS = TRAP;
    endcase
  end

  // Datapath controls decoded from the current state (Mealy on memReady/zero)
  always_comb begin
    rawPcWrite  = 1'b0;
    rawIrWrite  = 1'b0;
    rawMemRead  = 1'b0;
    rawMemWrite = 1'b0;
    rawRegWrite = 1'b0;
    pcSrc       = 1'b0;
    iorD        = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    case (stateR)
      FETCH: begin
        rawMemRead = 1'b1;
        aluSrcB    = 2'b01;
        rawIrWrite = memReady;
        rawPcWrite = memReady;
      end
      DECODE: aluSrcB = 2'b11;
      MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEMREAD: begin
        rawMemRead = 1'b1;
        iorD       = 1'b1;
      end
      MEMWB: begin
        rawRegWrite = 1'b1;
        memToReg    = 1'b1;
      end
      MEMWRITE: begin
        rawMemWrite = 1'b1;
        iorD        = 1'b1;
      end
      EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      RWB: begin
        rawRegWrite = 1'b1;
        regDst      = 1'b1;
      end
      BRANCH: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b01;
        pcSrc      = 1'b1;
        rawPcWrite = zero;
      end
      TRAP:    aluSrcB = 2'b00;
      default: aluSrcB = 2'b00;
    endcase
  end

  // Strobes are gated by reset so a mid-access reset kills them without waiting for a clock.
  assign pcWrite  = rawPcWrite  & resetN;
  assign irWrite  = rawIrWrite  & resetN;
  assign memRead  = rawMemRead  & resetN;
  assign memWrite = rawMemWrite & resetN;
  assign regWrite = rawRegWrite & resetN;
  assign state    = stateR;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: instruction-level reference model
// expands each instruction into its expected per-cycle state/control sequence.
module tb_multicycle_control;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          resetN;
  logic [5:0]    opCode;
  logic          zero;
  logic          memReady;
  logic          pcWrite, pcSrc, irWrite, iorD, memRead, memWrite;
  logic          memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]    aluSrcB, aluOp;
  logic          illegalOp, memTimeout;
  logic [3:0]    state;
  logic [CW-1:0] instrCount;
  logic [13:0]   actOut;

  int nVec = 0;
  int nErr = 0;
  int countExp = 0;

  typedef struct packed {logic [3:0] st; logic rdy;} cycT;
  cycT plan[$];

  multicycle_control #(.MAX_WAIT(16), .WAIT_W(8), .COUNT_W(CW)) dut (
    .clock(clock), .resetN(resetN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .pcSrc(pcSrc), .irWrite(irWrite), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regDst(regDst),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .illegalOp(illegalOp), .memTimeout(memTimeout), .state(state), .instrCount(instrCount)
  );

  always #5 clock = ~clock;

  assign actOut = {pcWrite, pcSrc, irWrite, iorD, memRead, memWrite, memToReg,
                   regDst, regWrite, aluSrcA, aluSrcB, aluOp};

  // Control table: {pcWrite,pcSrc,irWrite,iorD,memRead,memWrite,memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp}
  function automatic logic [13:0] expOut(logic [3:0] st, logic rdy, logic z);
    case (st)
      4'd0:    return {rdy, 1'b0, rdy, 1'b0, 1'b1, 5'b00000, 2'b01, 2'b00};
      4'd1:    return {10'b0000000000, 2'b11, 2'b00};
      4'd2:    return {9'b000000000, 1'b1, 2'b10, 2'b00};
      4'd3:    return {3'b000, 1'b1, 1'b1, 5'b00000, 2'b00, 2'b00};
      4'd4:    return {6'b000000, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00};
      4'd5:    return {3'b000, 1'b1, 1'b0, 1'b1, 4'b0000, 2'b00, 2'b00};
      4'd6:    return {9'b000000000, 1'b1, 2'b00, 2'b10};
      4'd7:    return {7'b0000000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
      4'd8:    return {z, 1'b1, 7'b0000000, 1'b1, 2'b00, 2'b01};
      default: return 14'b0;
    endcase
  endfunction

  function automatic void add(logic [3:0] s, logic r);
    plan.push_back({s, r});
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic doReset();
    resetN = 1'b0;
    memReady = 1'b0;
    @(negedge clock);
    nVec++;
    if (state !== 4'd0 || actOut !== 14'b00000000000100 || instrCount !== CW'(0) ||
        illegalOp !== 1'b0 || memTimeout !== 1'b0) begin
      nErr++;
      $display("FAIL reset: state=%0d out=%b cnt=%0d ill=%b to=%b want state=0 out=00000000000100 cnt=0 ill=0 to=0",
               state, actOut, instrCount, illegalOp, memTimeout);
    end
    @(posedge clock);
    #1 resetN = 1'b1;
    countExp = 0;
  endtask

  // Expand one instruction into its expected cycles, drive it, and check every cycle.
  task automatic runInstr(input logic [5:0] op, input logic z, input int w0, input int w1);
    bit legal;
    legal = (op == 6'd0 || op == 6'd4 || op == 6'd35 || op == 6'd43);
    plan.delete();
    for (int i = 0; i < w0; i++) add(4'd0, 1'b0);
    add(4'd0, 1'b1);
    add(4'd1, rnd1());
    case (op)
      6'd0: begin add(4'd6, rnd1()); add(4'd7, rnd1()); end
      6'd4: add(4'd8, rnd1());
      6'd35: begin
        add(4'd2, rnd1());
        for (int i = 0; i < w1; i++) add(4'd3, 1'b0);
        add(4'd3, 1'b1);
        add(4'd4, rnd1());
      end
      6'd43: begin
        add(4'd2, rnd1());
        for (int i = 0; i < w1; i++) add(4'd5, 1'b0);
        add(4'd5, 1'b1);
      end
      default: for (int i = 0; i < 20; i++) add(4'd9, rnd1());
    endcase
    for (int i = 0; i < plan.size(); i++) begin
      memReady = plan[i].rdy;
      opCode = (plan[i].st == 4'd0) ? 6'($urandom) : op;
      zero = z;
      @(negedge clock);
      nVec++;
      if (state !== plan[i].st) begin
        nErr++;
        $display("FAIL state op%0d cyc%0d: got %0d want %0d", op, i, state, plan[i].st);
      end
      nVec++;
      if (actOut !== expOut(plan[i].st, plan[i].rdy, z)) begin
        nErr++;
        $display("FAIL ctrl op%0d cyc%0d st%0d: got %b want %b", op, i, plan[i].st, actOut,
                 expOut(plan[i].st, plan[i].rdy, z));
      end
      @(posedge clock);
      #1;
    end
    if (legal) countExp = (countExp + 1) % (1 << CW);
    nVec++;
    if (instrCount !== CW'(countExp)) begin
      nErr++;
      $display("FAIL count op%0d: got %0d want %0d", op, instrCount, countExp);
    end
    nVec++;
    if (illegalOp !== !legal || memTimeout !== 1'b0) begin
      nErr++;
      $display("FAIL flags op%0d: ill=%b to=%b want ill=%b to=0", op, illegalOp, memTimeout, !legal);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0; opCode = 6'd0; zero = 1'b0; memReady = 1'b0;
    #12;
    doReset();
  endtask

  task automatic test_rtype();
    runInstr(6'd0, 1'b0, 0, 0);
  endtask

  task automatic test_lw();
    runInstr(6'd35, 1'b0, 0, 3);
    runInstr(6'd35, 1'b1, 2, 0);
  endtask

  task automatic test_sw();
    runInstr(6'd43, 1'b0, 0, 0);
    runInstr(6'd43, 1'b0, 1, 15);
  endtask

  task automatic test_beq();
    runInstr(6'd4, 1'b1, 0, 0);
    runInstr(6'd4, 1'b0, 0, 0);
  endtask

  task automatic test_watchdog_edge();
    runInstr(6'd0, 1'b0, 15, 0);
    runInstr(6'd35, 1'b0, 0, 15);
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    int w0, w1;
    ops[0] = 6'd0; ops[1] = 6'd4; ops[2] = 6'd35; ops[3] = 6'd43;
    for (int n = 0; n < 40; n++) begin
      w0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
      w1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
      runInstr(ops[$urandom_range(0, 3)], rnd1(), w0, w1);
    end
  endtask

  task automatic test_illegal();
    runInstr(6'd2, 1'b0, 0, 0);
    doReset();
    runInstr(6'(($urandom_range(0, 1) == 0) ? 63 : 12), 1'b1, 1, 0);
    doReset();
  endtask

  task automatic test_timeout();
    opCode = 6'd0;
    memReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      nVec++;
      if (state !== 4'd0 || memTimeout !== 1'b0) begin
        nErr++;
        $display("FAIL timeout-wait cyc%0d: state=%0d to=%b want state=0 to=0", i, state, memTimeout);
      end
      @(posedge clock);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      memReady = rnd1();
      @(negedge clock);
      nVec++;
      if (state !== 4'd9 || memTimeout !== 1'b1 || illegalOp !== 1'b0 ||
          actOut !== 14'b0 || instrCount !== CW'(0)) begin
        nErr++;
        $display("FAIL timeout-trap cyc%0d: state=%0d to=%b ill=%b out=%b cnt=%0d want 9 1 0 0 0",
                 i, state, memTimeout, illegalOp, actOut, instrCount);
      end
      @(posedge clock);
      #1;
    end
    doReset();
  endtask

  task automatic test_async_reset();
    runInstr(6'd0, 1'b0, 0, 0);
    memReady = 1'b1; opCode = 6'd43; zero = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    memReady = 1'b0;
    #2;
    nVec++;
    if (state !== 4'd5 || memWrite !== 1'b1) begin
      nErr++;
      $display("FAIL pre-reset: state=%0d memWrite=%b want 5 1", state, memWrite);
    end
    resetN = 1'b0;
    #1;
    nVec++;
    if (state !== 4'd0 || memWrite !== 1'b0 || memRead !== 1'b0 || instrCount !== CW'(0)) begin
      nErr++;
      $display("FAIL async-reset: state=%0d memWrite=%b memRead=%b cnt=%0d want 0 0 0 0",
               state, memWrite, memRead, instrCount);
    end
    @(posedge clock);
    #1 resetN = 1'b1;
    memReady = 1'b1;
    @(negedge clock);
    nVec++;
    if (state !== 4'd0 || instrCount !== CW'(0)) begin
      nErr++;
      $display("FAIL post-reset: state=%0d cnt=%0d want 0 0", state, instrCount);
    end
    @(posedge clock);
    #1;
    nVec++;
    if (state !== 4'd1) begin
      nErr++;
      $display("FAIL resume: state=%0d want 1", state);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw();
    test_sw();
    test_beq();
    test_watchdog_edge();
    test_random();
    test_illegal();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
